stack_arbiter: RTL and testbench

- Shares one stack datapath (stack control unit plus register file) between two requesters, e.g. the debounced button path and a UART/host path.
- Accepts push/pop requests over a req/ack handshake and arbitrates between the two requesters.
- Issues single-cycle push/pop strobes to the stack, captures pop data, and returns per-request status, including rejection on full or empty.

---
 rtl/stack_arbiter.sv | 163 ++++++++++++++++
 tb/tb_stack_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
// Two-requester arbiter in front of a shared stack: push/pop strobes, pop capture, per-request status.
// Optional STACK_ARB_RR_EN selects round-robin contention handling; otherwise requester 0 has fixed priority.
module stack_arbiter #(
    parameter int DATA_WIDTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [1:0]            ack,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic [DATA_WIDTH-1:0] stk_wdata,
    input  logic                  stk_full,
    input  logic                  stk_empty,
    input  logic [DATA_WIDTH-1:0] stk_rdata,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    // Handshake: a requester raises req[i] with op[i]/wdata_i stable and holds them
    // until ack[i] pulses for one cycle; err and rdata are valid in that same cycle.

    state_t                  state_q, state_d;
    logic                    sel_q, sel_d;
    logic                    op_q, op_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    grant;
    logic                    reject;

`ifdef STACK_ARB_RR_EN
    logic                    last_grant_q, last_grant_d;

    always_comb begin
        if (req == 2'b11) begin
            grant = ~last_grant_q;
        end else begin
            grant = ~req[0];
        end
    end
`else
    always_comb begin
        grant = ~req[0];
    end
`endif

    // Flags are only trusted in ISSUE, after the previous operation has settled.
    assign reject = op_q ? stk_full : stk_empty;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        op_d      = op_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
`ifdef STACK_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        ack       = 2'b00;
        err       = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_wdata = '0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    sel_d   = grant;
                    op_d    = op[grant];
                    wdata_d = grant ? wdata1 : wdata0;
                    err_d   = 1'b0;
`ifdef STACK_ARB_RR_EN
                    last_grant_d = grant;
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                stk_wdata = wdata_q;
                if (reject) begin
                    err_d = 1'b1;
                end else begin
                    stk_push = op_q;
                    stk_pop  = ~op_q;
                    if (!op_q) begin
                        rdata_d = stk_rdata;
                    end
                end
                cnt_d   = SETTLE_INIT;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                ack     = sel_q ? 2'b10 : 2'b01;
                err     = err_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            op_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef STACK_ARB_RR_EN
    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign rdata     = rdata_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Self-checking bench for stack_arbiter: behavioural stack environment plus a queue-based
// request-level reference model; honours STACK_ARB_RR_EN for contention expectations.
module tb_stack_arbiter;

    localparam int DW     = 4;
    localparam int SETTLE = 1;
    localparam int DEPTH  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [1:0]    op;
    logic [DW-1:0] wdata0, wdata1;
    logic [1:0]    ack;
    logic          err;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          stk_push, stk_pop;
    logic [DW-1:0] stk_wdata;
    logic          stk_full, stk_empty;
    logic [DW-1:0] stk_rdata;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    stack_arbiter #(.DATA_WIDTH(DW), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .reset(reset), .req(req), .op(op),
        .wdata0(wdata0), .wdata1(wdata1), .ack(ack), .err(err),
        .rdata(rdata), .busy(busy), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_wdata(stk_wdata), .stk_full(stk_full), .stk_empty(stk_empty),
        .stk_rdata(stk_rdata), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Stack environment: a plain register-file stack driven by the strobes.
    logic [DW-1:0] env_mem [DEPTH];
    int            env_sp = 0;

    assign stk_full  = (env_sp == DEPTH);
    assign stk_empty = (env_sp == 0);
    assign stk_rdata = (env_sp > 0) ? env_mem[(env_sp > 0) ? env_sp - 1 : 0] : '0;

    always @(posedge clk) begin
        if (stk_push && env_sp < DEPTH) begin
            env_mem[env_sp] <= stk_wdata;
            env_sp <= env_sp + 1;
        end else if (stk_pop && env_sp > 0) begin
            env_sp <= env_sp - 1;
        end
    end

    // Strobe monitor, sampled mid-cycle.
    int            push_cnt = 0;
    int            pop_cnt  = 0;
    int            both_cnt = 0;
    logic [DW-1:0] last_push_data = '0;

    always @(negedge clk) begin
        if (stk_push) begin
            push_cnt <= push_cnt + 1;
            last_push_data <= stk_wdata;
        end
        if (stk_pop) pop_cnt <= pop_cnt + 1;
        if (stk_push && stk_pop) both_cnt <= both_cnt + 1;
    end

    // Reference model: expected stack contents, last good pop word, last granted requester.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_rdata = '0;
    int            model_last  = 1;

    // driver tasks
    task automatic run_op(input int idx, input bit is_push, input logic [DW-1:0] data, input string tag);
        int            lat;
        bit            got;
        bit            exp_err;
        logic [1:0]    exp_ack;
        int            p0, q0, exp_p, exp_o;
        exp_err = is_push ? (exp_q.size() == DEPTH) : (exp_q.size() == 0);
        if (!exp_err) begin
            if (is_push) exp_q.push_back(data);
            else model_rdata = exp_q.pop_back();
        end
        exp_ack = (idx == 1) ? 2'b10 : 2'b01;
        exp_p = (is_push && !exp_err) ? 1 : 0;
        exp_o = (!is_push && !exp_err) ? 1 : 0;
        p0 = push_cnt;
        q0 = pop_cnt;
        req[idx] = 1'b1;
        op[idx]  = is_push;
        if (idx == 1) wdata1 = data;
        else wdata0 = data;
        lat = 1;
        got = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ack != 2'b00) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s ack_timeout got none within %0d cycles", tag, lat);
            req = 2'b00;
            @(negedge clk);
            return;
        end
        checks++;
        if (ack !== exp_ack) begin
            errors++;
            $display("FAIL %s ack got %b exp %b", tag, ack, exp_ack);
        end
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL %s err got %b exp %b", tag, err, exp_err);
        end
        checks++;
        if (lat != 3 + SETTLE) begin
            errors++;
            $display("FAIL %s latency got %0d exp %0d", tag, lat, 3 + SETTLE);
        end
        checks++;
        if (rdata !== model_rdata) begin
            errors++;
            $display("FAIL %s rdata got %h exp %h", tag, rdata, model_rdata);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_in_resp got %b exp 1", tag, busy);
        end
        checks++;
        if ((push_cnt - p0) != exp_p || (pop_cnt - q0) != exp_o) begin
            errors++;
            $display("FAIL %s strobes got push %0d pop %0d exp push %0d pop %0d",
                     tag, push_cnt - p0, pop_cnt - q0, exp_p, exp_o);
        end
        if (exp_p == 1) begin
            checks++;
            if (last_push_data !== data) begin
                errors++;
                $display("FAIL %s stk_wdata got %h exp %h", tag, last_push_data, data);
            end
        end
        model_last = idx;
        req[idx] = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) run_op($urandom_range(0, 1), 1'b0, '0, tag);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req = 2'b00; op = 2'b00; wdata0 = '0; wdata1 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (ack !== 2'b00 || err !== 1'b0 || rdata !== '0 || busy !== 1'b0 ||
            stk_push !== 1'b0 || stk_pop !== 1'b0 || stk_wdata !== '0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs got ack %b err %b rdata %h busy %b push %b pop %b wdata %h st %0d exp all 0",
                     ack, err, rdata, busy, stk_push, stk_pop, stk_wdata, dbg_state);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ack !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset got busy %b ack %b exp 0 00", busy, ack);
        end
    endtask

    task automatic test_push_pop();
        run_op(1, 1'b1, 4'h3, "r1_push3");
        run_op(1, 1'b0, '0, "r1_pop3");
    endtask

    task automatic test_pop_empty();
        run_op(0, 1'b0, '0, "pop_empty");
    endtask

    task automatic test_push_basic();
        run_op(0, 1'b1, 4'hA, "r0_pushA");
    endtask

    task automatic test_full();
        while (exp_q.size() < DEPTH) run_op($urandom_range(0, 1), 1'b1, DW'($urandom_range(0, 15)), "fill");
        run_op(0, 1'b1, 4'h7, "push_full");
        drain("drain_full");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_op($urandom_range(0, 1), 1'($urandom_range(0, 1)), DW'($urandom_range(0, 15)), "random");
        end
        drain("drain_random");
    endtask

    task automatic test_contention();
        int         w;
        int         n;
        bit         got;
        logic [1:0] exp_ack;
        run_op(1, 1'b1, 4'h9, "pre_push");
        run_op(1, 1'b0, '0, "pre_pop");
        req = 2'b11; op = 2'b11; wdata0 = 4'h1; wdata1 = 4'h2;
        for (int k = 0; k < 4; k++) begin
`ifdef STACK_ARB_RR_EN
            w = (model_last == 1) ? 0 : 1;
`else
            w = 0;
`endif
            exp_ack = (w == 1) ? 2'b10 : 2'b01;
            n = 0;
            got = 0;
            while (n < 40) begin
                @(posedge clk);
                n++;
                @(negedge clk);
                if (ack != 2'b00) begin
                    got = 1;
                    break;
                end
            end
            checks++;
            if (!got || ack !== exp_ack || err !== 1'b0) begin
                errors++;
                $display("FAIL contention_%0d got ack %b err %b exp ack %b err 0", k, ack, err, exp_ack);
            end
            exp_q.push_back((w == 1) ? 4'h2 : 4'h1);
            model_last = w;
        end
        req = 2'b00;
        @(negedge clk);
        drain("drain_contention");
    endtask

    task automatic test_reset_mid();
        int n;
        int acks;
        req[0] = 1'b1; op[0] = 1'b1; wdata0 = 4'h5;
        n = 0;
        while (n < 20 && !stk_push) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!stk_push) begin
            errors++;
            $display("FAIL reset_mid_strobe got none exp push strobe");
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (ack !== 2'b00 || err !== 1'b0 || rdata !== '0 || busy !== 1'b0 ||
            stk_push !== 1'b0 || stk_pop !== 1'b0 || stk_wdata !== '0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs got ack %b err %b rdata %h busy %b st %0d exp all 0",
                     ack, err, rdata, busy, dbg_state);
        end
        req = 2'b00;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack != 2'b00) acks++;
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack != 2'b00) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL reset_mid_no_ack got %0d acks exp 0", acks);
        end
        exp_q.push_back(4'h5);
        model_rdata = '0;
        model_last = 1;
        run_op(0, 1'b0, '0, "pop_after_reset");
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_pop_empty();
        test_push_basic();
        drain("drain_basic");
        test_full();
        test_random();
        test_contention();
        test_reset_mid();
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL push_pop_overlap got %0d cycles exp 0", both_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
